// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and requester indices.
// The control decoder imports the same codes.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SUBU = 4'b1110;
    localparam logic [3:0] ALU_SLL  = 4'b1111;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unknown control codes give 0 with the zero flag set.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        zero_f_o
);

    always_comb begin
        result_o = '0;
        unique case (ctrl_i)
            ALU_AND:            result_o = x_i & y_i;
            ALU_OR:             result_o = x_i | y_i;
            ALU_ADD, ALU_ADDU:  result_o = x_i + y_i;
            ALU_SUB, ALU_SUBU:  result_o = x_i - y_i;
            ALU_SLT:            result_o = {31'd0, ($signed(x_i) < $signed(y_i))};
            ALU_XOR:            result_o = x_i ^ y_i;
            ALU_NOR:            result_o = ~(x_i | y_i);
            ALU_SLL:            result_o = y_i << shamt_i;
            ALU_SRL:            result_o = y_i >> shamt_i;
            default:            result_o = '0;
        endcase
    end

    assign zero_f_o = (result_o == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin or fixed-priority
// arbitration feeding a one-entry result register with a valid/ready drain.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  op0,
    input  logic [3:0]  op1,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] y0,
    input  logic [31:0] y1,
    input  logic [4:0]  shamt0,
    input  logic [4:0]  shamt1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero
);

    logic        rsp_valid_q;
    logic [31:0] rsp_result_q;
    logic        rsp_zero_q;
    logic        rsp_id_q;
    logic        last_q;

    logic        space;
    logic        any_gnt;
    logic        win;
    logic [3:0]  alu_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;

    assign space = !rsp_valid_q || rsp_ready;

    // On a conflict, round-robin favours whoever was not served last.
    always_comb begin
        win = REQ_CORE;
        if (req0 && req1) begin
            win = PRIO_FIXED ? REQ_CORE : ~last_q;
        end else if (req1) begin
            win = REQ_DBG;
        end
    end

    assign any_gnt = space && !rst && (req0 || req1);
    assign gnt0    = any_gnt && (win == REQ_CORE);
    assign gnt1    = any_gnt && (win == REQ_DBG);

    assign alu_op    = (win == REQ_DBG) ? op1    : op0;
    assign alu_x     = (win == REQ_DBG) ? x1     : x0;
    assign alu_y     = (win == REQ_DBG) ? y1     : y0;
    assign alu_shamt = (win == REQ_DBG) ? shamt1 : shamt0;

    alu_arbiter_alu u_alu (
        .ctrl_i   (alu_op),
        .x_i      (alu_x),
        .y_i      (alu_y),
        .shamt_i  (alu_shamt),
        .result_o (alu_result),
        .zero_f_o (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= REQ_CORE;
            last_q       <= REQ_DBG;
        end else if (any_gnt) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            rsp_id_q     <= win;
            last_q       <= win;
        end else if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared each cycle against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] x0, x1, y0, y1;
    logic [4:0]  shamt0, shamt1;
    logic        rsp_ready;

    logic        gnt0_a, gnt1_a, rsp_valid_a, rsp_id_a, rsp_zero_a;
    logic [31:0] rsp_result_a;
    logic        gnt0_b, gnt1_b, rsp_valid_b, rsp_id_b, rsp_zero_b;
    logic [31:0] rsp_result_b;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: index 0 round-robin, index 1 fixed priority.
    bit          m_valid [2];
    logic [31:0] m_res   [2];
    bit          m_zero  [2];
    bit          m_id    [2];
    bit          m_last  [2];

    bit obs_g0 [2];
    bit obs_g1 [2];

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .shamt0(shamt0), .shamt1(shamt1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id_a), .rsp_result(rsp_result_a), .rsp_zero(rsp_zero_a)
    );

    alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .shamt0(shamt0), .shamt1(shamt1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id_b), .rsp_result(rsp_result_b), .rsp_zero(rsp_zero_b)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [4:0] sh);
        int signed xs = x;
        int signed ys = y;
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010, 4'b1010: return x + y;
            4'b0110, 4'b1110: return x - y;
            4'b0111: return (xs < ys) ? 32'd1 : 32'd0;
            4'b0101: return x ^ y;
            4'b1100: return ~(x | y);
            4'b1111: return y << sh;
            4'b1000: return y >> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic exp_gnt(input int k, output bit g0, output bit g1);
        bit space;
        space = !m_valid[k] || rsp_ready;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && space) begin
            if (req0 && req1) begin
                if (k == 1 || m_last[k]) g0 = 1'b1;
                else                     g1 = 1'b1;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_res[k]   = 32'd0;
            m_zero[k]  = 1'b0;
            m_id[k]    = 1'b0;
            m_last[k]  = 1'b1;
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic step();
        bit eg0 [2];
        bit eg1 [2];
        #1;
        for (int k = 0; k < 2; k++) exp_gnt(k, eg0[k], eg1[k]);
        obs_g0[0] = gnt0_a; obs_g1[0] = gnt1_a;
        obs_g0[1] = gnt0_b; obs_g1[1] = gnt1_b;
        chk("gnt0_rr", gnt0_a, eg0[0]);
        chk("gnt1_rr", gnt1_a, eg1[0]);
        chk("gnt0_fx", gnt0_b, eg0[1]);
        chk("gnt1_fx", gnt1_b, eg1[1]);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (eg0[k] || eg1[k]) begin
                    m_res[k]   = eg1[k] ? ref_alu(op1, x1, y1, shamt1) : ref_alu(op0, x0, y0, shamt0);
                    m_zero[k]  = (m_res[k] == 32'd0);
                    m_id[k]    = eg1[k];
                    m_last[k]  = eg1[k];
                    m_valid[k] = 1'b1;
                end else if (rsp_ready) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        #1;
        chk("valid_rr",  rsp_valid_a,  m_valid[0]);
        chk("result_rr", rsp_result_a, m_res[0]);
        chk("zero_rr",   rsp_zero_a,   m_zero[0]);
        chk("id_rr",     rsp_id_a,     m_id[0]);
        chk("valid_fx",  rsp_valid_b,  m_valid[1]);
        chk("result_fx", rsp_result_b, m_res[1]);
        chk("zero_fx",   rsp_zero_b,   m_zero[1]);
        chk("id_fx",     rsp_id_b,     m_id[1]);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zero;
    } op_vec_t;

    op_vec_t vecs [6];
    logic [3:0] codes [11];

    initial begin
        logic [31:0] held;
        vecs[0] = '{4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0};
        vecs[1] = '{4'b1111, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0};
        vecs[2] = '{4'b1000, 32'd0, 32'h8000_0000, 5'd31, 32'd1, 1'b0};
        vecs[3] = '{4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{4'b0110, 32'd4, 32'd4, 5'd0, 32'd0, 1'b1};
        vecs[5] = '{4'b0011, 32'd9, 32'd9, 5'd0, 32'd0, 1'b1};
        codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h5, 4'hC, 4'hF, 4'h8, 4'hA, 4'hE};

        model_reset();
        rst = 1'b1; rsp_ready = 1'b1;
        req0 = 1'b1; op0 = 4'b0010; x0 = 32'd5; y0 = 32'd7;  shamt0 = 5'd0;
        req1 = 1'b1; op1 = 4'b0110; x1 = 32'd3; y1 = 32'd10; shamt1 = 5'd0;
        @(posedge clk); #1;

        // Reset held two cycles with both requests up.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_gnt0", obs_g0[0], 1'b0);
            chk("rst_gnt1", obs_g1[0], 1'b0);
            chk("rst_valid", rsp_valid_a, 1'b0);
        end
        rst = 1'b0;

        // Round-robin conflict.
        step();
        chk("first_gnt0", obs_g0[0], 1'b1);
        chk("add_result", rsp_result_a, 32'd12);
        chk("add_id", rsp_id_a, 1'b0);
        step();
        chk("second_gnt1", obs_g1[0], 1'b1);
        chk("sub_result", rsp_result_a, 32'hFFFF_FFF9);
        chk("sub_id", rsp_id_a, 1'b1);
        chk("sub_zero", rsp_zero_a, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_alt", obs_g0[0], (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("fx_gnt0", obs_g0[1], 1'b1);
            chk("fx_gnt1", obs_g1[1], 1'b0);
        end

        // Stall with req1 pending.
        held = m_res[0];
        rsp_ready = 1'b0; req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_gnt1", obs_g1[0], 1'b0);
            chk("stall_hold", rsp_result_a, held);
        end
        rsp_ready = 1'b1;
        step();
        chk("refill_gnt1", obs_g1[0], 1'b1);
        chk("refill_result", rsp_result_a, 32'hFFFF_FFF9);

        // Op coverage through requester 1 alone.
        for (int i = 0; i < 6; i++) begin
            op1 = vecs[i].op; x1 = vecs[i].x; y1 = vecs[i].y; shamt1 = vecs[i].sh;
            step();
            chk("op_result", rsp_result_a, vecs[i].res);
            chk("op_zero", rsp_zero_a, vecs[i].zero);
        end

        // Reset while a result is stalled.
        rsp_ready = 1'b0;
        req1 = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", rsp_valid_a, 1'b0);
        chk("midrst_result", rsp_result_a, 32'd0);
        rst = 1'b0; rsp_ready = 1'b1; req0 = 1'b1; req1 = 1'b1;
        step();
        chk("postrst_gnt0", obs_g0[0], 1'b1);

        // Randomized traffic; requests stay stable until the round-robin DUT grants them.
        for (int i = 0; i < 400; i++) begin
            if (!req0 || obs_g0[0]) begin
                req0 = ($urandom_range(0, 3) != 0);
                op0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 10)];
                x0 = $urandom; y0 = $urandom; shamt0 = 5'($urandom_range(0, 31));
            end
            if (!req1 || obs_g1[0]) begin
                req1 = ($urandom_range(0, 2) != 0);
                op1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 10)];
                x1 = $urandom; y1 = ($urandom_range(0, 7) == 0) ? x1 : $urandom;
                shamt1 = 5'($urandom_range(0, 31));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
